// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters.
// Each result goes out through one registered, back-pressurable response slot tagged with the requester id.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [2:0]            req0_ctrl,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [2:0]            req1_ctrl,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_zero_q, rsp_zero_d;
    logic                  last_grant_q, last_grant_d;

    logic [1:0] valid_w;
    logic [1:0] grant_w;
    logic [1:0] ready_w;
    logic       slot_free;
    logic       accept;

    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [2:0]            op_ctrl;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] alu_result;

    assign valid_w   = {req1_valid, req0_valid};
    assign slot_free = !rsp_valid_q || rsp_ready;

    // A port wins when it is alone, or when the other port held the last grant.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign grant_w[gi] = valid_w[gi] &&
                             (!valid_w[1-gi] || (last_grant_q != 1'(gi)));
        assign ready_w[gi] = !rst && slot_free && grant_w[gi];
    end

    assign req0_ready = ready_w[0];
    assign req1_ready = ready_w[1];
    assign accept     = |ready_w;

    assign op_a    = grant_w[1] ? req1_a    : req0_a;
    assign op_b    = grant_w[1] ? req1_b    : req0_b;
    assign op_ctrl = grant_w[1] ? req1_ctrl : req0_ctrl;
    assign diff    = op_a - op_b;

    always_comb begin
        alu_result = '0;
        case (op_ctrl)
            3'b000:  alu_result = op_a + op_b;
            3'b001:  alu_result = diff;
            3'b010:  alu_result = op_a & op_b;
            3'b011:  alu_result = op_a | op_b;
            3'b100:  alu_result = op_a ^ op_b;
            3'b110:  alu_result = op_a << op_b[SHW-1:0];
            3'b111:  alu_result = op_a >> op_b[SHW-1:0];
            default: alu_result = '0;
        endcase
    end

    // Reload on accept even when draining, so a consume+accept cycle keeps full throughput.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = ready_w[1];
            rsp_result_d = alu_result;
            rsp_zero_d   = (diff == '0);
            last_grant_d = ready_w[1];
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: accepted ops queue hand-computed responses,
// and a monitor pops and compares them whenever a response is consumed.
module tb_alu_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]    req0_ctrl = '0, req1_ctrl = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_id;
    logic [DW-1:0] rsp_result;
    logic          rsp_zero;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] res;
        logic          zero;
    } rsp_t;

    rsp_t          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp0_r = '0, exp1_r = '0;
    logic          exp0_z = 1'b0, exp1_z = 1'b0;

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Accept tracker: sample handshakes mid-cycle, enqueue at the edge that commits them.
    rsp_t trk_it0, trk_it1;
    bit   trk_h0, trk_h1;
    initial begin
        forever begin
            @(negedge clk);
            trk_h0  = (req0_valid && req0_ready === 1'b1);
            trk_h1  = (req1_valid && req1_ready === 1'b1);
            trk_it0 = '{id: 1'b0, res: exp0_r, zero: exp0_z};
            trk_it1 = '{id: 1'b1, res: exp1_r, zero: exp1_z};
            @(posedge clk);
            if (trk_h0) exp_q.push_back(trk_it0);
            if (trk_h1) exp_q.push_back(trk_it1);
        end
    end

    rsp_t mon_e;
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && rsp_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got id=%0d res=%0h zero=%0d, expected no response",
                         rsp_id, rsp_result, rsp_zero);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_id, rsp_result, rsp_zero} !== mon_e) begin
                    n_err++;
                    $display("FAIL rsp: got id=%0d res=%0h zero=%0d, expected id=%0d res=%0h zero=%0d",
                             rsp_id, rsp_result, rsp_zero, mon_e.id, mon_e.res, mon_e.zero);
                end else begin
                    $display("rsp  id=%0d res=%0h zero=%0d", rsp_id, rsp_result, rsp_zero);
                end
            end
        end
    end

    task automatic load(input int port, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [2:0] c, input logic [DW-1:0] er, input logic ez);
        if (port == 0) begin
            req0_a = a; req0_b = b; req0_ctrl = c; exp0_r = er; exp0_z = ez; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_ctrl = c; exp1_r = er; exp1_z = ez; req1_valid = 1'b1;
        end
    endtask

    // Present one op and hold it until accepted; returns at edge+1 of the accepting edge.
    task automatic send(input int port, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [2:0] c, input logic [DW-1:0] er, input logic ez);
        bit done = 0;
        load(port, a, b, c, er, ez);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if ((port == 0 ? req0_ready : req1_ready) === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: port %0d got no ready, expected ready within 20 cycles", port);
        end
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    logic [DW-1:0] c_a[2][2], c_b[2][2], c_r[2][2];
    logic [2:0]    c_c[2][2];
    logic          c_z[2][2];
    int            idx[2];
    logic [1:0]    exp_gnt[4];

    initial begin
        // Reset with both requesters valid.
        rsp_ready = 1'b1;
        load(0, 32'hFFFF_FFFF, 32'h1, 3'b000, 32'h0, 1'b0);
        load(1, 32'h2, 32'h3, 3'b000, 32'h5, 1'b0);
        @(posedge clk); #1;
        chk("rst_readies_1", 64'({req1_ready, req0_ready}), 64'(2'b00));
        chk("rst_rsp_1", 64'({rsp_valid, rsp_id, rsp_zero, rsp_result}), 64'(0));
        @(posedge clk); #1;
        chk("rst_readies_2", 64'({req1_ready, req0_ready}), 64'(2'b00));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 64'({req1_ready, req0_ready}), 64'(2'b01));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Op sweep on port 0.
        send(0, 32'h5,         32'h5,         3'b001, 32'h0,         1'b1);
        send(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010, 32'h00F0_00F0, 1'b0);
        send(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, 32'hFFF0_FFF0, 1'b0);
        send(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100, 32'hFF00_FF00, 1'b0);
        send(0, 32'h1,         32'h21,        3'b110, 32'h2,         1'b0);
        send(0, 32'h8000_0000, 32'd31,        3'b111, 32'h1,         1'b0);
        send(0, 32'h7,         32'h7,         3'b101, 32'h0,         1'b1);
        send(0, 32'h7,         32'h9,         3'b101, 32'h0,         1'b0);

        // Single requester on port 1: three accepts with no bubbles.
        load(1, 32'd100, 32'd23, 3'b000, 32'd123, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("single_ready_%0d", i), 64'({req1_ready, req0_ready}), 64'(2'b10));
            @(posedge clk); #1;
            if (i == 0) load(1, 32'd3, 32'd5, 3'b001, 32'hFFFF_FFFE, 1'b0);
            if (i == 1) load(1, 32'h55, 32'h55, 3'b011, 32'h55, 1'b1);
        end
        req1_valid = 1'b0;

        // Continuous dual contention: grants must alternate 0,1,0,1.
        c_a[0][0] = 32'd1;   c_b[0][0] = 32'd2;   c_c[0][0] = 3'b000; c_r[0][0] = 32'd3;    c_z[0][0] = 1'b0;
        c_a[0][1] = 32'hFF;  c_b[0][1] = 32'h0F;  c_c[0][1] = 3'b010; c_r[0][1] = 32'h0F;   c_z[0][1] = 1'b0;
        c_a[1][0] = 32'd6;   c_b[1][0] = 32'd6;   c_c[1][0] = 3'b100; c_r[1][0] = 32'd0;    c_z[1][0] = 1'b1;
        c_a[1][1] = 32'd3;   c_b[1][1] = 32'd4;   c_c[1][1] = 3'b110; c_r[1][1] = 32'h30;   c_z[1][1] = 1'b0;
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
        idx[0] = 0; idx[1] = 0;
        for (int p = 0; p < 2; p++) load(p, c_a[p][0], c_b[p][0], c_c[p][0], c_r[p][0], c_z[p][0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("contend_grant_%0d", i), 64'({req1_ready, req0_ready}), 64'(exp_gnt[i]));
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (exp_gnt[i][p]) begin
                    idx[p]++;
                    if (idx[p] < 2)
                        load(p, c_a[p][idx[p]], c_b[p][idx[p]], c_c[p][idx[p]], c_r[p][idx[p]], c_z[p][idx[p]]);
                    else if (p == 0) req0_valid = 1'b0;
                    else req1_valid = 1'b0;
                end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Back-pressure: response held stable, readies low, then consume+accept together.
        send(0, 32'd3, 32'd4, 3'b011, 32'd7, 1'b0);
        rsp_ready = 1'b0;
        load(1, 32'd9, 32'd4, 3'b001, 32'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_readies_%0d", i), 64'({req1_ready, req0_ready}), 64'(2'b00));
            chk($sformatf("stall_rsp_%0d", i), 64'({rsp_valid, rsp_id, rsp_zero, rsp_result}),
                64'({1'b1, 1'b0, 1'b0, 32'd7}));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_accept", 64'({req1_ready, req0_ready}), 64'(2'b10));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        chk("release_rsp", 64'({rsp_valid, rsp_id}), 64'(2'b11));

        // Mid-op reset discards the held response and restores last_grant.
        send(0, 32'hF0, 32'h3C, 3'b010, 32'h30, 1'b0);
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("midrst_held", 64'(rsp_valid), 64'(1'b1));
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        chk("midrst_cleared", 64'(rsp_valid), 64'(1'b0));
        load(0, 32'd40, 32'd2, 3'b000, 32'd42, 1'b0);
        load(1, 32'd50, 32'd8, 3'b001, 32'd42, 1'b0);
        @(negedge clk);
        chk("midrst_first_win", 64'({req1_ready, req0_ready}), 64'(2'b01));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("midrst_second", 64'({req1_ready, req0_ready}), 64'(2'b10));
        @(posedge clk); #1;
        req1_valid = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU datapath between two requesters in the execute stage, e.g. the main integer pipe (port 0) and the branch/address-compare helper (port 1). Each requester presents operands and a 3-bit ALU control code with a valid/ready handshake. The block grants one requester per cycle using round-robin fairness. It computes the result and returns it through a single registered, back-pressurable response port tagged with the requester ID.

## Interface

- DATA_WIDTH, 32, operand/result width; a power of two, at least 8
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0's operation is accepted this cycle
- req0_a  in  DATA_WIDTH  operand A, requester 0
- req0_b  in  DATA_WIDTH  operand B, requester 0
- req0_ctrl  in  3  ALU control code, requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl: same as the port-0 signals, for requester 1
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes the response this cycle
- rsp_id  out  1  requester that issued the result
- rsp_result  out  DATA_WIDTH  ALU result
- rsp_zero  out  1  1 when A == B for that operation

## Operation

- ALU control codes:
  - 000 add: A+B
  - 001 sub: A−B
  - 010 and: A&B
  - 011 or: A|B
  - 100 xor: A^B
  - 110 sll: A << B[$clog2(DATA_WIDTH)-1:0]
  - 111 srl: A >> B[$clog2(DATA_WIDTH)-1:0], logical
  - 101 and anything else: result 0
- Add and sub wrap modulo 2^DATA_WIDTH; there is no carry or overflow output.
- rsp_zero = (A−B == 0). It is independent of the control code, matching the branch-compare use.
- Slot free: `slot_free = !rsp_valid || rsp_ready`.
- Grant, combinational:
  - only reqK_valid high: grant K
  - both valid: grant the requester not granted last (`last_grant`)
  - neither valid: no grant
- reqK_ready = slot_free && grant==K. At most one ready is high per cycle.
- reqK_ready must not depend on reqK_ready of the other port. It may depend on both valids.
- Accept occurs when reqK_valid && reqK_ready. At that edge:
  - the response register loads result, zero and id=K
  - rsp_valid is set
  - last_grant is set to K
- Consume without accept: rsp_valid && rsp_ready with no accept clears rsp_valid at the edge.
- Consume and accept in the same cycle: the register reloads with the new result and rsp_valid stays 1. Full throughput is one op per cycle.
- Stall: rsp_valid && !rsp_ready holds rsp_id, rsp_result and rsp_zero stable. Both readies are 0.
- Requesters must hold valid and payload stable until accepted. The block does not check this.
- State: response register (valid, id, result, zero) and the last_grant bit. There is no other FSM.

## Timing

- Reset values, at the first edge with rst=1:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0
  - last_grant=1, so requester 0 wins the first contention
- During rst: req0_ready=req1_ready=0, regardless of the valids.
- Reset mid-operation discards any held response without handshake. Requesters whose op was not accepted re-present it after reset.
- Latency: an op accepted at edge N is visible on rsp_* after edge N, i.e. in cycle N+1.
- Throughput: one accept per cycle while rsp_ready=1. Under continuous dual contention the grants alternate 0,1,0,1…
- Starvation bound: a valid requester is granted within 2 slot-free cycles.
- rsp_* are registered outputs. reqK_ready is combinational from the valids, rsp_valid, rsp_ready and last_grant.

## Test plan

- Reset: hold rst 2 cycles with both valids high -> readies 0, rsp_valid 0. On the first post-reset cycle, req0_ready=1 and req1_ready=0.
- Op sweep on port 0, rsp_ready=1, DATA_WIDTH=32:
  - A=0xFFFFFFFF, B=1, add -> 0x00000000, zero=0
  - A=5, B=5, sub -> 0, zero=1
  - A=0xF0F0F0F0, B=0x0FF00FF0: and -> 0x00F000F0, or -> 0xFFF0FFF0, xor -> 0xFF00FF00
  - A=1, B=0x21, sll -> 0x2
  - A=0x80000000, B=31, srl -> 1
  - ctrl 101 -> 0
- Contention: both valid for 4 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1 on consecutive cycles, with 4 results back-to-back.
- Back-pressure: accept op, then rsp_ready=0 for 3 cycles -> rsp_* stable, both readies 0. On rsp_ready=1, a pending req1 is accepted in that same cycle and rsp_valid stays 1.
- Single requester: only req1_valid for 3 cycles -> 3 accepts, ids all 1, no bubbles.
- Mid-op reset: rsp_valid=1 with rsp_ready=0, then rst pulse -> rsp_valid=0 next cycle. last_grant returns to 1, so requester 0 is next to win.
